// File: rtl/gemm_instr_sequencer.sv
// rtl/gemm_instr_sequencer.sv - expands one matrix-multiply job into LD_M/GEMM/ST_M words, or issues HALT
module gemm_instr_sequencer #(
    parameter int WORD_W   = 32,
    parameter int REG_W    = 5,
    parameter int MATRIX_W = 6,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [MATRIX_W-1:0] cmd_ma,
    input  logic [MATRIX_W-1:0] cmd_mb,
    input  logic [MATRIX_W-1:0] cmd_mc,
    input  logic [MATRIX_W-1:0] cmd_md,
    input  logic [REG_W-1:0]    cmd_rs_a,
    input  logic [REG_W-1:0]    cmd_rs_b,
    input  logic [REG_W-1:0]    cmd_rs_c,
    input  logic [REG_W-1:0]    cmd_rs_d,
    input  logic [REG_W-1:0]    cmd_rs_stride,
    input  logic                cmd_load_c,
    input  logic                cmd_store_d,
    input  logic                halt_req,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [WORD_W-1:0]   instr,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    issued_cnt
);
    localparam logic [6:0] OP_LD   = 7'b0000111;
    localparam logic [6:0] OP_ST   = 7'b0100111;
    localparam logic [6:0] OP_GEMM = 7'b1110011;
    localparam logic [WORD_W-1:0] HALT_WORD = WORD_W'(32'h0000_007F);

    typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_LDC, S_GEMM, S_STD, S_HLT} state_t;

    state_t state, state_n;
    logic [WORD_W-1:0] instr_n;
    logic              valid_n, halted_n, latch_en, fire;
    logic [CNT_W-1:0]  cnt_n;

    logic [MATRIX_W-1:0] ma_q, mb_q, mc_q, md_q;
    logic [REG_W-1:0]    rs_b_q, rs_c_q, rs_d_q, rs_stride_q;
    logic                load_c_q, store_d_q;

    function automatic logic [WORD_W-1:0] enc_mem(input logic [MATRIX_W-1:0] m,
                                                  input logic [REG_W-1:0] base,
                                                  input logic [REG_W-1:0] stride,
                                                  input logic [6:0] op);
        logic [WORD_W-1:0] w;
        w        = '0;
        w[31:26] = m;
        w[25:21] = base;
        w[20:16] = stride;
        w[6:0]   = op;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] enc_gemm(input logic [MATRIX_W-1:0] md,
                                                   input logic [MATRIX_W-1:0] ma,
                                                   input logic [MATRIX_W-1:0] mb,
                                                   input logic [MATRIX_W-1:0] mc);
        logic [WORD_W-1:0] w;
        w        = '0;
        w[31:26] = md;
        w[25:20] = ma;
        w[19:14] = mb;
        w[13:8]  = mc;
        w[6:0]   = OP_GEMM;
        return w;
    endfunction

    assign fire      = instr_valid && instr_ready;
    assign cmd_ready = (state == S_IDLE) && !halted;
    assign busy      = (state != S_IDLE);

    // Next word is computed here and registered, so the output never depends combinationally on inputs.
    always_comb begin
        state_n  = state;
        instr_n  = instr;
        valid_n  = instr_valid;
        halted_n = halted;
        latch_en = 1'b0;
        cnt_n    = fire ? issued_cnt + CNT_W'(1) : issued_cnt;
        unique case (state)
            S_IDLE: begin
                if (!halted) begin
                    if (cmd_valid) begin
                        latch_en = 1'b1;
                        state_n  = S_LDA;
                        valid_n  = 1'b1;
                        instr_n  = enc_mem(cmd_ma, cmd_rs_a, cmd_rs_stride, OP_LD);
                    end else if (halt_req) begin
                        state_n = S_HLT;
                        valid_n = 1'b1;
                        instr_n = HALT_WORD;
                    end
                end
            end
            S_LDA: if (fire) begin
                state_n = S_LDB;
                instr_n = enc_mem(mb_q, rs_b_q, rs_stride_q, OP_LD);
            end
            S_LDB: if (fire) begin
                if (load_c_q) begin
                    state_n = S_LDC;
                    instr_n = enc_mem(mc_q, rs_c_q, rs_stride_q, OP_LD);
                end else begin
                    state_n = S_GEMM;
                    instr_n = enc_gemm(md_q, ma_q, mb_q, mc_q);
                end
            end
            S_LDC: if (fire) begin
                state_n = S_GEMM;
                instr_n = enc_gemm(md_q, ma_q, mb_q, mc_q);
            end
            S_GEMM: if (fire) begin
                if (store_d_q) begin
                    state_n = S_STD;
                    instr_n = enc_mem(md_q, rs_d_q, rs_stride_q, OP_ST);
                end else begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                    instr_n = '0;
                end
            end
            S_STD: if (fire) begin
                state_n = S_IDLE;
                valid_n = 1'b0;
                instr_n = '0;
            end
            S_HLT: if (fire) begin
                state_n  = S_IDLE;
                valid_n  = 1'b0;
                instr_n  = '0;
                halted_n = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            state       <= state_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            halted      <= halted_n;
            issued_cnt  <= cnt_n;
        end
    end

    // Job fields are captured once so later cmd_* activity cannot corrupt an in-flight job.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ma_q <= '0; mb_q <= '0; mc_q <= '0; md_q <= '0;
            rs_b_q <= '0; rs_c_q <= '0; rs_d_q <= '0; rs_stride_q <= '0;
            load_c_q <= 1'b0; store_d_q <= 1'b0;
        end else if (latch_en) begin
            ma_q        <= cmd_ma;
            mb_q        <= cmd_mb;
            mc_q        <= cmd_mc;
            md_q        <= cmd_md;
            rs_b_q      <= cmd_rs_b;
            rs_c_q      <= cmd_rs_c;
            rs_d_q      <= cmd_rs_d;
            rs_stride_q <= cmd_rs_stride;
            load_c_q    <= cmd_load_c;
            store_d_q   <= cmd_store_d;
        end
    end
endmodule

// File: tb/tb_gemm_instr_sequencer.sv
// tb/tb_gemm_instr_sequencer.sv - table, directed and randomized checks of gemm_instr_sequencer
module tb_gemm_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_load_c, cmd_store_d, halt_req, instr_ready;
    logic [5:0]  cmd_ma, cmd_mb, cmd_mc, cmd_md;
    logic [4:0]  cmd_rs_a, cmd_rs_b, cmd_rs_c, cmd_rs_d, cmd_rs_stride;
    logic        cmd_ready, instr_valid, busy, halted;
    logic [31:0] instr;
    logic [15:0] issued_cnt;
    logic        s_cmd_ready, s_instr_valid, s_busy, s_halted;
    logic [31:0] s_instr;
    logic [3:0]  s_issued_cnt;

    always #5 clk = ~clk;

    gemm_instr_sequencer dut (
        .CLK(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ma(cmd_ma), .cmd_mb(cmd_mb), .cmd_mc(cmd_mc), .cmd_md(cmd_md),
        .cmd_rs_a(cmd_rs_a), .cmd_rs_b(cmd_rs_b), .cmd_rs_c(cmd_rs_c), .cmd_rs_d(cmd_rs_d),
        .cmd_rs_stride(cmd_rs_stride), .cmd_load_c(cmd_load_c), .cmd_store_d(cmd_store_d),
        .halt_req(halt_req), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .busy(busy), .halted(halted), .issued_cnt(issued_cnt)
    );

    gemm_instr_sequencer #(.CNT_W(4)) dut_small (
        .CLK(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_ma(cmd_ma), .cmd_mb(cmd_mb), .cmd_mc(cmd_mc), .cmd_md(cmd_md),
        .cmd_rs_a(cmd_rs_a), .cmd_rs_b(cmd_rs_b), .cmd_rs_c(cmd_rs_c), .cmd_rs_d(cmd_rs_d),
        .cmd_rs_stride(cmd_rs_stride), .cmd_load_c(cmd_load_c), .cmd_store_d(cmd_store_d),
        .halt_req(halt_req), .instr_valid(s_instr_valid), .instr_ready(instr_ready),
        .instr(s_instr), .busy(s_busy), .halted(s_halted), .issued_cnt(s_issued_cnt)
    );

    typedef struct {
        logic [5:0] ma, mb, mc, md;
        logic [4:0] ra, rb, rc, rd, rs;
        logic       lc, sd;
        int         stall_idx, stall_len, n;
        logic [4:0][31:0] w;
    } vec_t;

    vec_t        tab[6];
    logic [31:0] expq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_mem(input int m, input int base, input int stride, input int op);
        return 32'((m << 26) | (base << 21) | (stride << 16) | op);
    endfunction

    function automatic logic [31:0] m_gemm(input int md, input int ma, input int mb, input int mc);
        return 32'((md << 26) | (ma << 20) | (mb << 14) | (mc << 8) | 'h73);
    endfunction

    task automatic model_job(input vec_t v);
        expq.push_back(m_mem(v.ma, v.ra, v.rs, 'h07));
        expq.push_back(m_mem(v.mb, v.rb, v.rs, 'h07));
        if (v.lc) expq.push_back(m_mem(v.mc, v.rc, v.rs, 'h07));
        expq.push_back(m_gemm(v.md, v.ma, v.mb, v.mc));
        if (v.sd) expq.push_back(m_mem(v.md, v.rd, v.rs, 'h27));
    endtask

    task automatic scramble_cmd();
        {cmd_ma, cmd_mb, cmd_mc, cmd_md} = 24'($urandom);
        {cmd_rs_a, cmd_rs_b, cmd_rs_c, cmd_rs_d, cmd_rs_stride} = 25'($urandom);
        {cmd_load_c, cmd_store_d} = 2'($urandom);
    endtask

    task automatic run_job(input vec_t v, input bit rnd_ready, input bit with_halt);
        int budget = 0;
        int widx = 0;
        int stall = 0;
        bit hold = 0;
        logic [31:0] prev_w = '0;
        exp_cnt += expq.size();
        while (!cmd_ready && budget < 50) begin @(posedge clk); #1; budget++; end
        chk("cmd_ready_before_job", {31'b0, cmd_ready}, 32'd1);
        {cmd_ma, cmd_mb, cmd_mc, cmd_md} = {v.ma, v.mb, v.mc, v.md};
        {cmd_rs_a, cmd_rs_b, cmd_rs_c, cmd_rs_d, cmd_rs_stride} = {v.ra, v.rb, v.rc, v.rd, v.rs};
        {cmd_load_c, cmd_store_d} = {v.lc, v.sd};
        cmd_valid = 1'b1;
        halt_req = with_halt;
        instr_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        halt_req = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        chk("cmd_ready_after_accept", {31'b0, cmd_ready}, 32'd0);
        budget = 0;
        while (expq.size() > 0 && budget < 200) begin
            if (widx == v.stall_idx && stall < v.stall_len) begin
                instr_ready = 1'b0;
                stall++;
            end else begin
                instr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            scramble_cmd();
            cmd_valid = 1'($urandom);
            halt_req = 1'($urandom);
            chk($sformatf("no_bubble_w%0d", widx), {31'b0, instr_valid}, 32'd1);
            if (hold) chk($sformatf("hold_w%0d", widx), instr, prev_w);
            if (instr_valid && instr_ready) begin
                chk($sformatf("word%0d", widx), instr, expq.pop_front());
                widx++;
            end
            hold = instr_valid && !instr_ready;
            prev_w = instr;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            halt_req = 1'b0;
            budget++;
        end
        if (expq.size() > 0) begin
            chk("job_timeout", 32'(expq.size()), 32'd0);
            expq.delete();
        end
        instr_ready = 1'b0;
        chk("valid_after_job", {31'b0, instr_valid}, 32'd0);
        chk("busy_after_job", {31'b0, busy}, 32'd0);
        chk("cmd_ready_after_job", {31'b0, cmd_ready}, 32'd1);
        chk("issued_cnt", {16'b0, issued_cnt}, 32'(exp_cnt[15:0]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{6'd1, 6'd2, 6'd0, 6'd3, 5'd5, 5'd8, 5'd0, 5'd7, 5'd6, 1'b0, 1'b1, -1, 0, 4,
                   {32'h0, 32'h0CE60027, 32'h0C108073, 32'h09060007, 32'h04A60007}};
        tab[1] = tab[0];
        tab[1].stall_idx = 1;
        tab[1].stall_len = 3;
        tab[2] = '{6'd1, 6'd2, 6'd4, 6'd3, 5'd5, 5'd8, 5'd9, 5'd7, 5'd6, 1'b1, 1'b0, -1, 0, 4,
                   {32'h0, 32'h0C108473, 32'h11260007, 32'h09060007, 32'h04A60007}};
        tab[3] = '{6'd1, 6'd2, 6'd4, 6'd3, 5'd5, 5'd8, 5'd9, 5'd7, 5'd6, 1'b1, 1'b1, 2, 2, 5,
                   {32'h0CE60027, 32'h0C108473, 32'h11260007, 32'h09060007, 32'h04A60007}};
        tab[4] = '{6'd63, 6'd63, 6'd63, 6'd63, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, -1, 0, 3,
                   {32'h0, 32'h0, 32'hFFFFFF73, 32'hFFFF0007, 32'hFFFF0007}};
        tab[5] = '{6'd5, 6'd5, 6'd5, 6'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 4, 1, 5,
                   {32'h14000027, 32'h14514573, 32'h14000007, 32'h14000007, 32'h14000007}};

        rst = 1'b1; cmd_valid = 1'b0; halt_req = 1'b0; instr_ready = 1'b0;
        scramble_cmd();
        do_reset();
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_issued_cnt", {16'b0, issued_cnt}, 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < tab[i].n; k++) expq.push_back(tab[i].w[k]);
            run_job(tab[i], 1'b0, 1'b0);
        end

        for (int j = 0; j < 25; j++) begin
            vec_t v;
            {v.ma, v.mb, v.mc, v.md} = 24'($urandom);
            {v.ra, v.rb, v.rc, v.rd, v.rs} = 25'($urandom);
            {v.lc, v.sd} = 2'($urandom);
            v.stall_idx = -1; v.stall_len = 0; v.n = 0; v.w = '0;
            model_job(v);
            run_job(v, 1'b1, 1'b0);
        end

        // cmd_valid and halt_req together: job wins, HALT follows
        model_job(tab[0]);
        run_job(tab[0], 1'b0, 1'b1);
        halt_req = 1'b1;
        @(posedge clk); #1;
        halt_req = 1'b0;
        chk("halt_word_valid", {31'b0, instr_valid}, 32'd1);
        chk("halt_word", instr, 32'h0000007F);
        chk("halt_not_yet", {31'b0, halted}, 32'd0);
        instr_ready = 1'b1;
        exp_cnt++;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("halted_set", {31'b0, halted}, 32'd1);
        chk("halt_cnt", {16'b0, issued_cnt}, 32'(exp_cnt[15:0]));
        cmd_valid = 1'b1; halt_req = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("halted_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("halted_no_issue", {31'b0, instr_valid}, 32'd0);
            chk("halted_sticky", {31'b0, halted}, 32'd1);
        end
        cmd_valid = 1'b0; halt_req = 1'b0; instr_ready = 1'b0;

        // reset while LDB word is pending
        do_reset();
        {cmd_ma, cmd_mb, cmd_mc, cmd_md} = {6'd1, 6'd2, 6'd0, 6'd3};
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("ldb_pending", {31'b0, instr_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_cnt", {16'b0, issued_cnt}, 32'd0);
        chk("midrst_halted", {31'b0, halted}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // 17 fires wrap a 4-bit counter to 1
        do_reset();
        model_job(tab[3]); run_job(tab[3], 1'b0, 1'b0);
        model_job(tab[2]); run_job(tab[2], 1'b0, 1'b0);
        model_job(tab[0]); run_job(tab[0], 1'b0, 1'b0);
        model_job(tab[2]); run_job(tab[2], 1'b0, 1'b0);
        chk("wrap_small_cnt", {28'b0, s_issued_cnt}, 32'd1);
        chk("wrap_main_cnt", {16'b0, issued_cnt}, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
